spu_mald_mq: RTL

- Parametrised successor to the SPU modular-arithmetic load sequencer.
- Fetches a programmable number of lines from L2 into MA memory, keeping up to MAX_OUTST line requests in flight instead of one.
- Writes each returned line as WPL consecutive memory beats, with one cycle of parity-generation delay per line.
- Supports a clean drain on uncorrectable error or store-ASI force-abort, and keeps sticky completion and error status for the later masync return.

---
 rtl/spu_mald_mq_if.sv | 20 ++
 rtl/spu_mald_mq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spu_mald_mq_if.sv
// L2 request/return and MA-memory write strobes of the load sequencer.
interface spu_mald_mq_if;
  logic ldreq;
  logic ldreq_ack;
  logic ln_received;
  logic unc_err;
  logic memwen;
  logic maaddr_inc;
  logic mpa_inc;

  modport master (
    output ldreq, mpa_inc, memwen, maaddr_inc,
    input  ldreq_ack, ln_received, unc_err
  );

  modport slave (
    input  ldreq, mpa_inc, memwen, maaddr_inc,
    output ldreq_ack, ln_received, unc_err
  );
endinterface

// File: rtl/spu_mald_mq.sv
// Multi-outstanding L2-to-MA-memory load sequencer with error drain and sticky status.
module spu_mald_mq #(
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned WPL       = 2
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             se,
  input  logic             start,
  input  logic [LEN_W-1:0] start_len,
  input  logic             force_abort,
  spu_mald_mq_if.master    l2,
  output logic             busy,
  output logic             done,
  output logic             done_set,
  output logic             err_set,
  output logic [2:0]       outst_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam int unsigned       BEAT_W    = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WPL - 1);
  localparam logic [2:0]        MAX_O     = 3'(MAX_OUTST);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  req_left_q, req_left_d;
  logic [LEN_W-1:0]  ln_left_q, ln_left_d;
  logic [2:0]        outst_q, outst_d;
  logic [2:0]        pend_q, pend_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              wact_q, wact_d;
  logic              done_q, done_d;
  logic              done_set_q, done_set_d;
  logic              err_set_q, err_set_d;

  logic run, last_beat, par, abort, req, ack, rx_ok, wr, wr_last;
  logic unused_se;

  assign unused_se = se;

  // A parity cycle is due whenever a received line is not yet being written;
  // it may overlap the last beat of the line ahead of it.
  assign run       = (state_q == RUN);
  assign last_beat = (beat_q == LAST_BEAT);
  assign par       = run & (wact_q ? (last_beat & (pend_q > 3'd1)) : (pend_q != 3'd0));
  assign abort     = run & (l2.unc_err | (force_abort & par));
  assign req       = run & ~abort & (req_left_q != '0) & (outst_q < MAX_O);
  assign ack       = req & l2.ldreq_ack;
  assign wr        = run & wact_q & ~abort;
  assign wr_last   = wr & last_beat;
  assign rx_ok     = l2.ln_received & (outst_q != 3'd0);

  assign l2.ldreq      = req;
  assign l2.mpa_inc    = ack;
  assign l2.memwen     = wr;
  assign l2.maaddr_inc = wr;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign done_set  = done_set_q;
  assign err_set   = err_set_q;
  assign outst_cnt = outst_q;

  always_comb begin
    state_d    = state_q;
    req_left_d = req_left_q;
    ln_left_d  = ln_left_q;
    outst_d    = outst_q;
    pend_d     = pend_q;
    beat_d     = beat_q;
    wact_d     = wact_q;
    done_d     = 1'b0;
    done_set_d = done_set_q;
    err_set_d  = err_set_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_set_d = 1'b0;
          err_set_d  = 1'b0;
          if (start_len != '0) begin
            state_d    = RUN;
            req_left_d = start_len;
            ln_left_d  = start_len;
            outst_d    = '0;
            pend_d     = '0;
            beat_d     = '0;
            wact_d     = 1'b0;
          end else begin
            done_d     = 1'b1;
            done_set_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d   = DRAIN;
          err_set_d = 1'b1;
          pend_d    = '0;
          wact_d    = 1'b0;
          beat_d    = '0;
          if (rx_ok) outst_d = outst_q - 3'd1;
        end else begin
          if (l2.ln_received && !rx_ok) err_set_d = 1'b1;
          outst_d    = outst_q + {2'b0, ack} - {2'b0, rx_ok};
          req_left_d = req_left_q - LEN_W'(ack);
          pend_d     = pend_q + {2'b0, rx_ok} - {2'b0, wr_last};
          if (wr) begin
            if (wr_last) begin
              ln_left_d = ln_left_q - LEN_W'(1);
              beat_d    = '0;
              wact_d    = par;
              if (ln_left_q == LEN_W'(1)) begin
                state_d    = IDLE;
                wact_d     = 1'b0;
                done_d     = 1'b1;
                done_set_d = 1'b1;
              end
            end else begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end else if (par) begin
            wact_d = 1'b1;
            beat_d = '0;
          end
        end
      end

      DRAIN: begin
        if (outst_q == 3'd0) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          done_set_d = 1'b1;
        end else if (l2.ln_received) begin
          outst_d = outst_q - 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q    <= IDLE;
      req_left_q <= '0;
      ln_left_q  <= '0;
      outst_q    <= '0;
      pend_q     <= '0;
      beat_q     <= '0;
      wact_q     <= 1'b0;
      done_q     <= 1'b0;
      done_set_q <= 1'b0;
      err_set_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_left_q <= req_left_d;
      ln_left_q  <= ln_left_d;
      outst_q    <= outst_d;
      pend_q     <= pend_d;
      beat_q     <= beat_d;
      wact_q     <= wact_d;
      done_q     <= done_d;
      done_set_q <= done_set_d;
      err_set_q  <= err_set_d;
    end
  end

endmodule
